// File: rtl/permutation_ctrl.sv
// Round sequencer for the ASCON permutation: issues the initial-state load, the round
// index run for pA or pB, and a one-cycle completion pulse.
module permutation_ctrl #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 8,
  parameter int unsigned ROUND_W  = 4
) (
  input  logic               clock_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic               abort_i,
  output logic               init_state_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               en_perm_o,
  output logic               last_round_o,
  output logic               busy_o,
  output logic               done_o
);

  if ((ROUNDS_A < 1) || (ROUNDS_A > 12) || (ROUNDS_B < 1) || (ROUNDS_B > 12) ||
      (ROUND_W < 4)) begin : gen_param_err
    $error("permutation_ctrl: ROUNDS_A/ROUNDS_B must be 1..12 and ROUND_W >= 4");
  end

  localparam logic [ROUND_W-1:0] FirstIdxA = ROUND_W'(12 - ROUNDS_A);
  localparam logic [ROUND_W-1:0] FirstIdxB = ROUND_W'(12 - ROUNDS_B);
  localparam logic [ROUND_W-1:0] LastIdx   = ROUND_W'(11);

  typedef enum logic [1:0] {StIdle, StFirst, StRun, StDone} state_e;

  state_e             state_q;
  logic [ROUND_W-1:0] cnt_q;
  logic               mode_q;
  logic               first_last;

  // Single-round configuration: the FIRST cycle is also the final round.
  assign first_last = mode_q ? (ROUNDS_B == 1) : (ROUNDS_A == 1);

  always_ff @(posedge clock_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            mode_q  <= mode_i;
            cnt_q   <= mode_i ? FirstIdxB : FirstIdxA;
            state_q <= StFirst;
          end else begin
            state_q <= StIdle;
          end
        end
        StFirst: begin
          if (abort_i) begin
            state_q <= StIdle;
          end else if (first_last) begin
            state_q <= StDone;
          end else begin
            cnt_q   <= cnt_q + ROUND_W'(1);
            state_q <= StRun;
          end
        end
        StRun: begin
          if (abort_i) begin
            state_q <= StIdle;
          end else if (cnt_q == LastIdx) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + ROUND_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs depend only on registered state and counter.
  always_comb begin
    init_state_o = 1'b0;
    round_o      = '0;
    en_perm_o    = 1'b0;
    last_round_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      StFirst: begin
        init_state_o = 1'b1;
        round_o      = cnt_q;
        en_perm_o    = 1'b1;
        last_round_o = first_last;
        busy_o       = 1'b1;
      end
      StRun: begin
        round_o      = cnt_q;
        en_perm_o    = 1'b1;
        last_round_o = (cnt_q == LastIdx);
        busy_o       = 1'b1;
      end
      StDone: begin
        round_o = cnt_q;
        busy_o  = 1'b1;
        done_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Self-checking bench for permutation_ctrl: table of directed vectors plus hand-written
// sequences for back-to-back runs and asynchronous reset.
module tb_permutation_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       start, mode, abort;
  logic       init_state, en_perm, last_round, busy, done;
  logic [3:0] round;
  logic [8:0] act;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       start;
    logic       mode;
    logic       abort;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  permutation_ctrl #(
    .ROUNDS_A(12),
    .ROUNDS_B(8),
    .ROUND_W (4)
  ) dut (
    .clock_i     (clock),
    .rst_i       (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .abort_i     (abort),
    .init_state_o(init_state),
    .round_o     (round),
    .en_perm_o   (en_perm),
    .last_round_o(last_round),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clock = ~clock;

  assign act = {init_state, round, en_perm, last_round, busy, done};

  // Packed expectation: {init, round[3:0], en, last, busy, done}.
  function automatic logic [8:0] e(bit i, int r, bit en, bit l, bit b, bit d);
    return {i, 4'(r), en, l, b, d};
  endfunction

  task automatic add(bit s, bit m, bit a, logic [8:0] x);
    vec_t v;
    v.start = s;
    v.mode  = m;
    v.abort = a;
    v.exp   = x;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {init,round,en,last,busy,done}=%b_%0d_%b%b%b%b expected %b_%0d_%b%b%b%b",
               name, act[8], act[7:4], act[3], act[2], act[1], act[0],
               exp[8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  localparam logic [8:0] Idle = 9'b0;

  initial begin
    // Test 1: pA run, rounds 0..11, done in cycle 13, then idle.
    add(1, 0, 0, e(1, 0, 1, 0, 1, 0));
    for (int r = 1; r <= 10; r++) add(0, 0, 0, e(0, r, 1, 0, 1, 0));
    add(0, 0, 0, e(0, 11, 1, 1, 1, 0));
    add(0, 0, 0, e(0, 11, 0, 0, 1, 1));
    add(0, 0, 0, Idle);
    // Test 2: pB run, rounds 4..11, done in cycle 9.
    add(1, 1, 0, e(1, 4, 1, 0, 1, 0));
    for (int r = 5; r <= 10; r++) add(0, 1, 0, e(0, r, 1, 0, 1, 0));
    add(0, 0, 0, e(0, 11, 1, 1, 1, 0));
    add(0, 0, 0, e(0, 11, 0, 0, 1, 1));
    add(0, 0, 0, Idle);
    add(0, 1, 1, Idle);  // abort in IDLE does nothing
    add(0, 0, 0, Idle);
    // Test 4: start and mode toggle at round 5 are ignored.
    add(1, 0, 0, e(1, 0, 1, 0, 1, 0));
    for (int r = 1; r <= 5; r++) add(0, 0, 0, e(0, r, 1, 0, 1, 0));
    add(1, 1, 0, e(0, 6, 1, 0, 1, 0));
    for (int r = 7; r <= 10; r++) add(0, 1, 0, e(0, r, 1, 0, 1, 0));
    add(0, 0, 0, e(0, 11, 1, 1, 1, 0));
    add(0, 0, 0, e(0, 11, 0, 0, 1, 1));
    add(0, 0, 0, Idle);
    // Test 5: abort at round 7, then a fresh start begins at round 0; abort in FIRST.
    add(1, 0, 0, e(1, 0, 1, 0, 1, 0));
    for (int r = 1; r <= 7; r++) add(0, 0, 0, e(0, r, 1, 0, 1, 0));
    add(0, 0, 1, Idle);
    add(0, 0, 0, Idle);
    add(1, 0, 0, e(1, 0, 1, 0, 1, 0));
    add(0, 0, 1, Idle);
    add(0, 0, 0, Idle);
    // Abort together with start in DONE: start wins, mode 0 latched.
    add(1, 1, 0, e(1, 4, 1, 0, 1, 0));
    for (int r = 5; r <= 10; r++) add(0, 1, 0, e(0, r, 1, 0, 1, 0));
    add(0, 1, 0, e(0, 11, 1, 1, 1, 0));
    add(0, 1, 0, e(0, 11, 0, 0, 1, 1));
    add(1, 0, 1, e(1, 0, 1, 0, 1, 0));
    add(0, 0, 0, e(0, 1, 1, 0, 1, 0));
    add(0, 0, 1, Idle);

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    abort = 1'b0;
    #3;
    check("reset_state", Idle);
    #9 rst_n = 1'b1;
    step();
    check("idle_after_reset", Idle);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start;
      mode  = tbl[i].mode;
      abort = tbl[i].abort;
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    start = 1'b0;
    mode  = 1'b0;
    abort = 1'b0;

    // Test 3: start held high in pB mode repeats with period 9.
    start = 1'b1;
    mode  = 1'b1;
    step();
    for (int c = 0; c < 27; c++) begin
      int p;
      p = c % 9;
      check($sformatf("b2b_c%0d", c),
            (p < 8) ? e(p == 0, 4 + p, 1, p == 7, 1, 0) : e(0, 11, 0, 0, 1, 1));
      step();
    end
    start = 1'b0;
    for (int c = 0; c < 8; c++) step();
    check("b2b_drain_done", e(0, 11, 0, 0, 1, 1));
    step();
    check("b2b_drain_idle", Idle);

    // Test 6: asynchronous reset mid-run at round 3.
    start = 1'b1;
    mode  = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("pre_rst_round3", e(0, 3, 1, 0, 1, 0));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_immediate", Idle);
    step();
    check("rst_held", Idle);
    #2 rst_n = 1'b1;
    step();
    step();
    check("post_rst_idle", Idle);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r <= 11; r++) begin
      check($sformatf("p12_r%0d", r), e(r == 0, r, 1, r == 11, 1, 0));
      step();
    end
    check("p12_done", e(0, 11, 0, 0, 1, 1));
    step();
    check("p12_idle", Idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
